// File: rtl/rnrz_pkg.sv
// Shared constants for the RNRZ scrambler/descrambler and BER checker.
// Latency: n/a (constants only).
// Backpressure: n/a.
package rnrz_pkg;

  // BER checker states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HUNT   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // Feedback taps: sr[TAP_A] ^ sr[TAP15] for x^15+x^14+1,
  // sr[TAP_A] ^ sr[TAP11] for x^11+x^9+1 (sr[0] is the oldest bit)
  localparam int TAP_A  = 0;
  localparam int TAP15  = 1;
  localparam int TAP11  = 2;

  // Reseed value for the shift register
  localparam logic [14:0] SEED = 15'h7FFF;

endpackage

// File: rtl/rnrz_lfsr_step.sv
// Advances the scrambler shift register by W bits and returns the W coded bits.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to commit sr_out.
module rnrz_lfsr_step
  import rnrz_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [14:0]  sr_in,
  input  logic [W-1:0] din,
  input  logic         mode_15_n11,
  input  logic         tx_nrx,
  output logic [14:0]  sr_out,
  output logic [W-1:0] dout
);

  logic [14:0]  sr_v;
  logic [W-1:0] out_v;
  logic         fb;
  logic         o;
  logic         sh;

  // Bit-serial unroll: bit 0 first, each tap read after earlier bits shifted in.
  // TX feeds back its own output, RX feeds back the received bit.
  always_comb begin
    sr_v  = sr_in;
    out_v = '0;
    fb    = 1'b0;
    o     = 1'b0;
    sh    = 1'b0;
    for (int i = 0; i < W; i++) begin
      fb       = sr_v[TAP_A] ^ (mode_15_n11 ? sr_v[TAP15] : sr_v[TAP11]);
      o        = din[i] ^ fb;
      out_v[i] = o;
      sh       = tx_nrx ? o : din[i];
      if (mode_15_n11) begin
        sr_v = {sh, sr_v[14:1]};
      end else begin
        // 11-bit register lives in sr[10:0]; upper bits pinned high
        sr_v = {SEED[14:11], sh, sr_v[10:1]};
      end
    end
    sr_out = sr_v;
    dout   = out_v;
  end

endmodule

// File: rtl/rnrz_codec_ber.sv
// RNRZ-15/11 multiplicative scrambler/descrambler with a lock-based BER checker.
// Latency: data_out/data_valid 1 clk after the data_clk rising edge; BER state 1 clk after data_valid.
// Backpressure: none; every strobe is accepted except one coinciding with a mode/direction change.
module rnrz_codec_ber
  import rnrz_pkg::*;
#(
  parameter int W      = 1,
  parameter int ERR_W  = 16,
  parameter int CNT_W  = 32,
  parameter int LOCK_N = 32,
  parameter int WIN    = 64,
  parameter int LOSS_N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     data_in,
  input  logic             data_clk,
  input  logic             mode_15_n11,
  input  logic             tx_nrx,
  input  logic             ber_en,
  input  logic             ber_clr,
  output logic [W-1:0]     data_out,
  output logic             data_valid,
  output logic             ber_lock,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int HW = $clog2(LOCK_N + 1);
  localparam int WW = $clog2(WIN + 1);

  logic             data_clk_d;
  logic             mode_d;
  logic             tx_d;
  logic             data_en;
  logic             cfg_chg;
  logic [14:0]      sr;
  logic [14:0]      sr_nxt;
  logic [W-1:0]     step_out;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [HW-1:0]    hunt_cnt;
  logic [HW-1:0]    hunt_nxt;
  logic [HW-1:0]    hunt_run;
  logic [WW-1:0]    win_bits;
  logic [WW-1:0]    win_errs;
  logic [WW-1:0]    win_bits_nxt;
  logic [WW-1:0]    win_errs_nxt;
  logic [WW-1:0]    win_bits_add;
  logic [WW-1:0]    win_errs_add;
  logic [3:0]       pop;
  logic             cnt_upd;
  logic [ERR_W:0]   err_sum;
  logic [CNT_W:0]   bit_sum;

  assign data_en = data_clk & ~data_clk_d;
  assign cfg_chg = (mode_15_n11 != mode_d) | (tx_nrx != tx_d);

  rnrz_lfsr_step #(.W(W)) u_step (
    .sr_in       (sr),
    .din         (data_in),
    .mode_15_n11 (mode_15_n11),
    .tx_nrx      (tx_nrx),
    .sr_out      (sr_nxt),
    .dout        (step_out)
  );

  // Strobe edge detect and config history; config tracks its input during reset
  // so leaving reset never looks like a mode change.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_clk_d <= 1'b0;
      mode_d     <= mode_15_n11;
      tx_d       <= tx_nrx;
    end else begin
      data_clk_d <= data_clk;
      mode_d     <= mode_15_n11;
      tx_d       <= tx_nrx;
    end
  end

  // Datapath: commit one step per strobe; a config change reseeds and drops the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr         <= SEED;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (cfg_chg) begin
        sr <= SEED;
      end else if (data_en) begin
        sr         <= sr_nxt;
        data_out   <= step_out;
        data_valid <= 1'b1;
      end
    end
  end

  // Checker next state: error popcount, zero-run tracking, window accounting.
  always_comb begin
    pop = '0;
    for (int i = 0; i < W; i++) pop = pop + 4'(data_out[i]);
    hunt_run = hunt_cnt;
    for (int i = 0; i < W; i++) begin
      if (data_out[i])                   hunt_run = '0;
      else if (hunt_run != HW'(LOCK_N))  hunt_run = hunt_run + 1'b1;
    end
    win_bits_add = win_bits + WW'(W);
    win_errs_add = win_errs + WW'(pop);

    state_nxt    = state;
    hunt_nxt     = hunt_cnt;
    win_bits_nxt = win_bits;
    win_errs_nxt = win_errs;
    cnt_upd      = 1'b0;

    if (!ber_en || tx_nrx) begin
      state_nxt    = ST_IDLE;
      hunt_nxt     = '0;
      win_bits_nxt = '0;
      win_errs_nxt = '0;
    end else if (cfg_chg) begin
      state_nxt    = ST_HUNT;
      hunt_nxt     = '0;
      win_bits_nxt = '0;
      win_errs_nxt = '0;
    end else begin
      case (state)
        ST_HUNT: begin
          if (data_valid) begin
            hunt_nxt = hunt_run;
            if (hunt_run == HW'(LOCK_N)) begin
              state_nxt    = ST_LOCKED;
              hunt_nxt     = '0;
              win_bits_nxt = '0;
              win_errs_nxt = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (data_valid) begin
            cnt_upd = 1'b1;
            if (win_errs_add >= WW'(LOSS_N)) begin
              state_nxt    = ST_HUNT;
              hunt_nxt     = '0;
              win_bits_nxt = '0;
              win_errs_nxt = '0;
            end else if (win_bits_add >= WW'(WIN)) begin
              win_bits_nxt = '0;
              win_errs_nxt = '0;
            end else begin
              win_bits_nxt = win_bits_add;
              win_errs_nxt = win_errs_add;
            end
          end
        end
        default: begin
          state_nxt    = ST_HUNT;
          hunt_nxt     = '0;
          win_bits_nxt = '0;
          win_errs_nxt = '0;
        end
      endcase
    end

    err_sum = {1'b0, err_cnt} + (ERR_W + 1)'(pop);
    bit_sum = {1'b0, bit_cnt} + (CNT_W + 1)'(W);
  end

  // Checker state and registered lock flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ber_lock <= 1'b0;
      hunt_cnt <= '0;
      win_bits <= '0;
      win_errs <= '0;
    end else begin
      state    <= state_nxt;
      ber_lock <= (state_nxt == ST_LOCKED);
      hunt_cnt <= hunt_nxt;
      win_bits <= win_bits_nxt;
      win_errs <= win_errs_nxt;
    end
  end

  // Saturating totals; clear wins over a same-cycle update, survive lock loss.
  always_ff @(posedge clk) begin
    if (rst || ber_clr) begin
      err_cnt <= '0;
      bit_cnt <= '0;
    end else if (cnt_upd) begin
      err_cnt <= err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
      bit_cnt <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_rnrz_codec_ber.sv
// Self-checking bench: W=1 codec with a 4-bit error counter plus a W=4 TX->RX loopback pair.
// Latency: outputs sampled on the falling edge after each strobe.
// Backpressure: none.
module tb_rnrz_codec_ber;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:0]  data_in;
  logic        data_clk;
  logic        mode_15_n11;
  logic        tx_nrx;
  logic        ber_en;
  logic        ber_clr;
  logic [0:0]  data_out;
  logic        data_valid;
  logic        ber_lock;
  logic [3:0]  err_cnt;
  logic [31:0] bit_cnt;

  logic [3:0]  lb_din;
  logic        lb_clk;
  logic [3:0]  tx4_out;
  logic        tx4_vld;
  logic        tx4_lock;
  logic [15:0] tx4_err;
  logic [31:0] tx4_bits;
  logic [3:0]  rx4_out;
  logic        rx4_vld;
  logic        rx4_lock;
  logic [15:0] rx4_err;
  logic [31:0] rx4_bits;

  int errors = 0;
  int checks = 0;

  logic        sbq[$];
  logic [3:0]  lbq[$];
  int          lb_idx = 0;
  logic [63:0] hist;
  logic        mdl_mode;
  int          exp_err;

  typedef struct {
    logic din;
    logic exp;
  } vec_t;
  vec_t vec[30];

  always #5 clk = ~clk;

  rnrz_codec_ber #(.W(1), .ERR_W(4)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_clk(data_clk),
    .mode_15_n11(mode_15_n11), .tx_nrx(tx_nrx), .ber_en(ber_en), .ber_clr(ber_clr),
    .data_out(data_out), .data_valid(data_valid), .ber_lock(ber_lock),
    .err_cnt(err_cnt), .bit_cnt(bit_cnt)
  );

  rnrz_codec_ber #(.W(4)) u_tx4 (
    .clk(clk), .rst(rst), .data_in(lb_din), .data_clk(lb_clk),
    .mode_15_n11(1'b0), .tx_nrx(1'b1), .ber_en(1'b0), .ber_clr(1'b0),
    .data_out(tx4_out), .data_valid(tx4_vld), .ber_lock(tx4_lock),
    .err_cnt(tx4_err), .bit_cnt(tx4_bits)
  );

  rnrz_codec_ber #(.W(4)) u_rx4 (
    .clk(clk), .rst(rst), .data_in(tx4_out), .data_clk(tx4_vld),
    .mode_15_n11(1'b0), .tx_nrx(1'b0), .ber_en(1'b1), .ber_clr(1'b0),
    .data_out(rx4_out), .data_valid(rx4_vld), .ber_lock(rx4_lock),
    .err_cnt(rx4_err), .bit_cnt(rx4_bits)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference scrambler: hist[k] is the coded bit emitted k+1 steps ago.
  task automatic scramble(input logic p, output logic c);
    logic fb;
    fb   = mdl_mode ? (hist[14] ^ hist[13]) : (hist[10] ^ hist[8]);
    c    = p ^ fb;
    hist = {hist[62:0], c};
  endtask

  // One strobe: high one cycle, low one cycle; expected output queued at drive time.
  task automatic strobe(input logic d, input logic exp, input logic clr);
    @(negedge clk);
    data_in  = d;
    data_clk = 1'b1;
    sbq.push_back(exp);
    @(negedge clk);
    data_clk = 1'b0;
    ber_clr  = clr;
    check("valid_pulse", {31'd0, data_valid}, 32'd1);
    @(negedge clk);
    ber_clr = 1'b0;
    check("valid_drop", {31'd0, data_valid}, 32'd0);
    check("out_hold", {31'd0, data_out}, {31'd0, exp});
  endtask

  // Scramble a plaintext bit in the model and feed it to the descrambling DUT.
  task automatic rx_bit(input logic p, input logic clr);
    logic c;
    scramble(p, c);
    strobe(c, p, clr);
  endtask

  // Scoreboard for the main DUT
  always @(negedge clk) begin
    if (!rst && data_valid) begin
      if (sbq.size() == 0) begin
        check("sb_unexpected_valid", 32'd1, 32'd0);
      end else begin
        check("sb_data", {31'd0, data_out}, {31'd0, sbq.pop_front()});
      end
    end
  end

  // Scoreboard for the loopback pair; the first 11 bits (3 words) are sync time
  always @(negedge clk) begin
    if (!rst && rx4_vld) begin
      if (lbq.size() == 0) begin
        check("lb_unexpected_valid", 32'd1, 32'd0);
      end else begin
        logic [3:0] e;
        e = lbq.pop_front();
        if (lb_idx >= 3) check("lb_data", {28'd0, rx4_out}, {28'd0, e});
        lb_idx++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [29:0] pat;
    rst = 1'b1; data_in = '0; data_clk = 1'b0; mode_15_n11 = 1'b1; tx_nrx = 1'b1;
    ber_en = 1'b0; ber_clr = 1'b0; lb_din = '0; lb_clk = 1'b0;

    // First 30 bits of x^15+x^14+1 from all-ones with zero input: ones at 14, 28, 29
    pat = 30'h3000_4000;
    for (int i = 0; i < 30; i++) begin
      vec[i].din = 1'b0;
      vec[i].exp = pat[i];
    end

    repeat (3) @(negedge clk);
    check("rst_data_out", {31'd0, data_out}, 32'd0);
    check("rst_data_valid", {31'd0, data_valid}, 32'd0);
    check("rst_ber_lock", {31'd0, ber_lock}, 32'd0);
    check("rst_err_cnt", {28'd0, err_cnt}, 32'd0);
    check("rst_bit_cnt", bit_cnt, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // TX, 15 mode, zeros from reset
    for (int i = 0; i < 30; i++) strobe(vec[i].din, vec[i].exp, 1'b0);
    check("tx_idle_lock", {31'd0, ber_lock}, 32'd0);

    // Switch to RX with checker enabled; model reseeds
    @(negedge clk);
    tx_nrx = 1'b0;
    ber_en = 1'b1;
    repeat (2) @(negedge clk);
    hist = '1;
    mdl_mode = 1'b1;
    for (int i = 0; i < 31; i++) rx_bit(1'b0, 1'b0);
    check("hunt_31_zeros", {31'd0, ber_lock}, 32'd0);
    rx_bit(1'b0, 1'b0);
    check("lock_32_zeros", {31'd0, ber_lock}, 32'd1);
    check("lock_err_cnt", {28'd0, err_cnt}, 32'd0);
    check("lock_bit_cnt", bit_cnt, 32'd0);

    // One error per 8 bits: 8th error in the 64-bit window drops lock
    exp_err = 0;
    for (int k = 0; k < 64; k++) begin
      logic p;
      p = ((k % 8) == 7);
      rx_bit(p, 1'b0);
      if (p) begin
        exp_err++;
        check("err_step", {28'd0, err_cnt}, exp_err);
      end
      if (k == 55) check("lock_7_errs", {31'd0, ber_lock}, 32'd1);
    end
    check("loss_lock", {31'd0, ber_lock}, 32'd0);
    check("loss_err_cnt", {28'd0, err_cnt}, 32'd8);
    check("loss_bit_cnt", bit_cnt, 32'd64);
    for (int i = 0; i < 4; i++) rx_bit(1'b0, 1'b0);
    check("retain_err_cnt", {28'd0, err_cnt}, 32'd8);
    check("retain_bit_cnt", bit_cnt, 32'd64);

    // Relock, then sustained errors (1 per 10 bits, below loss threshold)
    for (int i = 0; i < 28; i++) rx_bit(1'b0, 1'b0);
    check("relock", {31'd0, ber_lock}, 32'd1);
    for (int k = 1; k <= 100; k++) begin
      logic p;
      p = ((k % 10) == 0);
      rx_bit(p, 1'b0);
      if (p) begin
        if (exp_err < 15) exp_err++;
        check("err_sat_step", {28'd0, err_cnt}, exp_err);
      end
    end
    check("err_saturated", {28'd0, err_cnt}, 32'd15);
    check("bits_after_sat", bit_cnt, 32'd164);
    check("lock_during_sat", {31'd0, ber_lock}, 32'd1);
    rx_bit(1'b1, 1'b1);
    check("clr_err_cnt", {28'd0, err_cnt}, 32'd0);
    check("clr_bit_cnt", bit_cnt, 32'd0);
    check("clr_keeps_lock", {31'd0, ber_lock}, 32'd1);

    // Mode toggle with a coincident strobe: strobe dropped, reseed, back to HUNT
    @(negedge clk);
    mode_15_n11 = 1'b0;
    data_in     = 1'b1;
    data_clk    = 1'b1;
    @(negedge clk);
    data_clk = 1'b0;
    check("toggle_strobe_ignored", {31'd0, data_valid}, 32'd0);
    @(negedge clk);
    check("toggle_hunt", {31'd0, ber_lock}, 32'd0);
    check("toggle_no_valid", {31'd0, data_valid}, 32'd0);
    hist = '1;
    mdl_mode = 1'b0;
    for (int i = 0; i < 20; i++) rx_bit(1'b0, 1'b0);
    rx_bit(1'b1, 1'b0);
    for (int i = 0; i < 31; i++) rx_bit(1'b0, 1'b0);
    check("one_clears_run", {31'd0, ber_lock}, 32'd0);
    rx_bit(1'b0, 1'b0);
    check("lock_11_mode", {31'd0, ber_lock}, 32'd1);

    // W=4 loopback in 11 mode with random data
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lb_din = 4'($urandom_range(0, 15));
      lb_clk = 1'b1;
      lbq.push_back(lb_din);
      @(negedge clk);
      lb_clk = 1'b0;
    end
    repeat (6) @(negedge clk);
    check("lb_drained", lbq.size(), 32'd0);
    check("lb_words", lb_idx, 32'd20);
    check("sb_drained", sbq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
